// File: rtl/demux2_8b_stream.sv
// 1-to-2 registered stream demultiplexer with a small FIFO per lane.
// Latency 1 cycle from accept to lane head; a full selected lane deasserts in_ready, and the other lane is unaffected.

module demux2_8b_stream_lane #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop_rdy,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_head_vld,
  output logic             o_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   OCC_ONE = 1;
  localparam logic [AW:0]   OCC_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_occ;
  logic             w_pop;

  assign o_head_vld = (r_occ != '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_full     = (r_occ == OCC_MAX);
  assign w_pop      = o_head_vld && i_pop_rdy;

  // Storage is cleared on reset so the head reads 0 until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({i_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end
endmodule

module demux2_8b_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic             w_full0;
  logic             w_full1;
  logic             w_push0;
  logic             w_push1;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Readiness looks only at the selected lane, never at in_valid.
  assign in_ready = !rst && !(in_sel ? w_full1 : w_full0);
  assign w_push0  = in_valid && in_ready && !in_sel;
  assign w_push1  = in_valid && in_ready &&  in_sel;
  assign cnt0     = r_cnt0;
  assign cnt1     = r_cnt1;

  demux2_8b_stream_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push0),
    .i_push_dat (in_data),
    .i_pop_rdy  (out0_ready),
    .o_head_dat (out0_data),
    .o_head_vld (out0_valid),
    .o_full     (w_full0)
  );

  demux2_8b_stream_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push1),
    .i_push_dat (in_data),
    .i_pop_rdy  (out1_ready),
    .o_head_dat (out1_data),
    .o_head_vld (out1_valid),
    .o_full     (w_full1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_push0) r_cnt0 <= r_cnt0 + CNT_ONE;
      if (w_push1) r_cnt1 <= r_cnt1 + CNT_ONE;
    end
  end
endmodule
